// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP computer datapath.
//   - SAP opcode constants and the canonical NOP instruction word
//   - fetch-stage state encoding
//   - default address/data widths and fetch acknowledge timeout
package sap_pkg;

  localparam int unsigned SAP_ADDR_W      = 4;
  localparam int unsigned SAP_DATA_W      = 8;
  localparam int unsigned SAP_ACK_TIMEOUT = 15;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_STA  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_INCA = 4'b0100;
  localparam logic [3:0] OP_DECR = 4'b0101;
  localparam logic [3:0] OP_JMPZ = 4'b0110;
  localparam logic [3:0] OP_NOP  = 4'b0111;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [7:0] SAP_NOP_INSTR = {OP_NOP, 4'h0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/sap_pc.sv
// sap_pc: program counter for the SAP fetch stage.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (PC -> 0)
//   load_i     in   load PC from load_val_i (has priority over inc_i)
//   load_val_i in   ADDR_W load value
//   inc_i      in   increment PC, wrapping modulo 2^ADDR_W
//   pc_o       out  ADDR_W current PC
module sap_pc
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/sap_fetch_unit.sv
// sap_fetch_unit: instruction fetch stage of the SAP computer.
// Holds PC and IR and runs a req/ack fetch from program memory on request
// from the control unit.
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   fetch_start  in   fetch next instruction (sampled in IDLE)
//   jump_en      in   load PC from jump_addr (sampled in IDLE)
//   jump_addr    in   jump target
//   halt         in   enter HALT (sampled in IDLE)
//   mem_req      out  memory fetch request
//   mem_addr     out  fetch address, stable while mem_req
//   mem_ack      in   mem_rdata valid this cycle
//   mem_rdata    in   instruction word
//   opcode       out  IR[7:4]
//   operand      out  IR[3:0]
//   instr_valid  out  one-cycle pulse after IR load
//   pc           out  current PC
//   busy         out  high in REQ and DONE
//   fetch_err    out  sticky ack-timeout flag, cleared by the next fetch
//   halted       out  high in HALT
module sap_fetch_unit
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W      = SAP_ADDR_W,
  parameter int unsigned DATA_W      = SAP_DATA_W,
  parameter int unsigned ACK_TIMEOUT = SAP_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_w;

  sap_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (pc_load),
    .load_val_i (jump_addr),
    .inc_i      (pc_inc),
    .pc_o       (pc_w)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (jump_en) begin
          pc_load = 1'b1;
          if (fetch_start) begin
            mem_addr_d = jump_addr;
            err_d      = 1'b0;
            cnt_d      = '0;
            state_d    = ST_REQ;
          end
        end else if (fetch_start) begin
          mem_addr_d = pc_w;
          err_d      = 1'b0;
          cnt_d      = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          // PC always equals mem_addr throughout REQ, so incrementing the
          // PC yields mem_addr+1.
          pc_inc  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          ir_d    = DATA_W'(SAP_NOP_INSTR);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      ir_q       <= DATA_W'(SAP_NOP_INSTR);
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Status outputs decode the state register directly, so reset clears
  // them asynchronously.
  assign mem_req     = (state_q == ST_REQ);
  assign busy        = (state_q == ST_REQ) || (state_q == ST_DONE);
  assign instr_valid = (state_q == ST_DONE);
  assign halted      = (state_q == ST_HALT);
  assign mem_addr    = mem_addr_q;
  assign opcode      = ir_q[DATA_W-1 -: 4];
  assign operand     = ir_q[3:0];
  assign pc          = pc_w;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_sap_fetch_unit.sv
module tb_sap_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_start, jump_en, halt, mem_ack;
  logic [3:0] jump_addr;
  logic [7:0] mem_rdata;
  logic       mem_req, instr_valid, busy, fetch_err, halted;
  logic [3:0] mem_addr, opcode, operand, pc;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  sap_fetch_unit #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, ".pc"},          32'(pc),          32'h0);
    chk_eq({tag, ".mem_addr"},    32'(mem_addr),    32'h0);
    chk_eq({tag, ".opcode"},      32'(opcode),      32'h7);
    chk_eq({tag, ".operand"},     32'(operand),     32'h0);
    chk_eq({tag, ".mem_req"},     32'(mem_req),     32'h0);
    chk_eq({tag, ".instr_valid"}, 32'(instr_valid), 32'h0);
    chk_eq({tag, ".busy"},        32'(busy),        32'h0);
    chk_eq({tag, ".fetch_err"},   32'(fetch_err),   32'h0);
    chk_eq({tag, ".halted"},      32'(halted),      32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned req_cycles;
    rst = 1'b1; fetch_start = 1'b0; jump_en = 1'b0; halt = 1'b0;
    mem_ack = 1'b0; jump_addr = 4'h0; mem_rdata = 8'h00;
    #1 rst = 1'b0;
    #2 chk_reset_outputs("reset");
    step();
    rst = 1'b1;

    // Single-cycle ack: 8'h2A at address 0.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk_eq("t1.mem_req", 32'(mem_req), 32'h1);
    chk_eq("t1.mem_addr", 32'(mem_addr), 32'h0);
    chk_eq("t1.busy", 32'(busy), 32'h1);
    mem_ack = 1'b1; mem_rdata = 8'h2A;
    step();
    mem_ack = 1'b0;
    chk_eq("t1.valid", 32'(instr_valid), 32'h1);
    chk_eq("t1.opcode", 32'(opcode), 32'h2);
    chk_eq("t1.operand", 32'(operand), 32'hA);
    chk_eq("t1.pc", 32'(pc), 32'h1);
    step();
    chk_eq("t1.valid_drop", 32'(instr_valid), 32'h0);
    chk_eq("t1.idle_busy", 32'(busy), 32'h0);

    // Ack three cycles late; fetch_start pulses while busy are ignored.
    fetch_start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      fetch_start = (i % 2 == 0);
      step();
      chk_eq("t2.mem_req_hold", 32'(mem_req), 32'h1);
      chk_eq("t2.mem_addr_hold", 32'(mem_addr), 32'h1);
      chk_eq("t2.no_valid", 32'(instr_valid), 32'h0);
    end
    mem_ack = 1'b1; mem_rdata = 8'h35; fetch_start = 1'b1;
    step();
    mem_ack = 1'b0;
    chk_eq("t2.valid", 32'(instr_valid), 32'h1);
    chk_eq("t2.opcode", 32'(opcode), 32'h3);
    chk_eq("t2.operand", 32'(operand), 32'h5);
    chk_eq("t2.pc", 32'(pc), 32'h2);
    step();
    fetch_start = 1'b0;
    chk_eq("t2.single_valid", 32'(instr_valid), 32'h0);
    chk_eq("t2.done_start_ignored", 32'(mem_req), 32'h0);
    chk_eq("t2.idle_busy", 32'(busy), 32'h0);

    // PC at 4'hF wraps to 0 after a fetch.
    jump_en = 1'b1; jump_addr = 4'hF;
    step();
    jump_en = 1'b0;
    chk_eq("t3.jump_pc", 32'(pc), 32'hF);
    chk_eq("t3.jump_no_req", 32'(mem_req), 32'h0);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk_eq("t3.mem_addr", 32'(mem_addr), 32'hF);
    mem_ack = 1'b1; mem_rdata = 8'h4C;
    step();
    mem_ack = 1'b0;
    chk_eq("t3.pc_wrap", 32'(pc), 32'h0);
    chk_eq("t3.opcode", 32'(opcode), 32'h4);
    step();

    // Jump and fetch in the same cycle fetch the jump target.
    jump_en = 1'b1; jump_addr = 4'h9; fetch_start = 1'b1;
    step();
    jump_en = 1'b0; fetch_start = 1'b0;
    chk_eq("t4.mem_req", 32'(mem_req), 32'h1);
    chk_eq("t4.mem_addr", 32'(mem_addr), 32'h9);
    mem_ack = 1'b1; mem_rdata = 8'h1B;
    step();
    mem_ack = 1'b0;
    chk_eq("t4.pc", 32'(pc), 32'hA);
    chk_eq("t4.opcode", 32'(opcode), 32'h1);
    chk_eq("t4.operand", 32'(operand), 32'hB);
    step();

    // No ack: timeout after exactly 15 REQ cycles.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      chk_eq("t5.no_err_in_req", 32'(fetch_err), 32'h0);
      step();
    end
    chk_eq("t5.req_cycles", req_cycles, 32'd15);
    chk_eq("t5.fetch_err", 32'(fetch_err), 32'h1);
    chk_eq("t5.opcode_nop", 32'(opcode), 32'h7);
    chk_eq("t5.operand_nop", 32'(operand), 32'h0);
    chk_eq("t5.pc_kept", 32'(pc), 32'hA);
    chk_eq("t5.busy", 32'(busy), 32'h0);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk_eq("t5.err_cleared", 32'(fetch_err), 32'h0);
    chk_eq("t5.refetch_addr", 32'(mem_addr), 32'hA);
    mem_ack = 1'b1; mem_rdata = 8'h6E;
    step();
    mem_ack = 1'b0;
    chk_eq("t5.pc", 32'(pc), 32'hB);
    chk_eq("t5.opcode", 32'(opcode), 32'h6);
    step();

    // Reset asserted mid-REQ clears everything without a clock edge.
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    chk_eq("t6.in_req", 32'(mem_req), 32'h1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midreq_reset");
    step();
    rst = 1'b1;

    // Halt wins over fetch_start; only reset leaves HALT.
    halt = 1'b1; fetch_start = 1'b1;
    step();
    halt = 1'b0; jump_en = 1'b1; jump_addr = 4'h5;
    mem_ack = 1'b1; mem_rdata = 8'hF1;
    for (int i = 0; i < 4; i++) begin
      chk_eq("t7.halted", 32'(halted), 32'h1);
      chk_eq("t7.no_req", 32'(mem_req), 32'h0);
      chk_eq("t7.pc_frozen", 32'(pc), 32'h0);
      chk_eq("t7.ir_frozen", 32'(opcode), 32'h7);
      step();
    end
    fetch_start = 1'b0; jump_en = 1'b0; mem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 chk_eq("t7.halt_reset", 32'(halted), 32'h0);
    step();
    rst = 1'b1;
    step();
    chk_eq("t7.idle_after_reset", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
